// File: rtl/counter_sync_down.sv
// rtl/counter_sync_down.sv - synchronous down counter with load, wrap/one-shot modes and terminal-count flags
module counter_sync_down #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow,
    output logic             done
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic             borrow_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_RUN;
            count  <= CNT_MAX;
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            borrow <= borrow_next;
            done   <= (state_next == S_HALT);
        end
    end

    // load beats en in any state; HALT only leaves through load or rst
    always_comb begin
        state_next  = state;
        count_next  = count;
        borrow_next = 1'b0;
        if (load) begin
            count_next = load_val;
            state_next = S_RUN;
        end else if (state == S_RUN && en) begin
            if (count != '0) begin
                count_next = count - 1'b1;
            end else if (!mode) begin
                count_next  = CNT_MAX;
                borrow_next = 1'b1;
            end else begin
                state_next = S_HALT;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_counter_sync_down.sv
// tb/tb_counter_sync_down.sv - directed plus random checks of counter_sync_down at WIDTH 4 and 8
module tb_counter_sync_down;

    logic       clk = 1'b0;
    logic       rst, en, load, mode;
    logic [3:0] lv4;
    logic [7:0] lv8;
    logic [3:0] c4;
    logic [7:0] c8;
    logic       z4, b4, d4, z8, b8, d8;

    int compared   = 0;
    int mismatched = 0;

    int m_cnt  [2];
    bit m_halt [2];
    bit m_brw  [2];
    int m_max  [2] = '{15, 255};

    always #5 clk = ~clk;

    counter_sync_down #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv4), .mode(mode),
        .count(c4), .zero(z4), .borrow(b4), .done(d4)
    );

    counter_sync_down #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv8), .mode(mode),
        .count(c8), .zero(z8), .borrow(b8), .done(d8)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour: integer counter following the edge rules in priority order
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int lv;
            lv = (i == 0) ? int'(lv4) : int'(lv8);
            if (rst) begin
                m_cnt[i] = m_max[i]; m_halt[i] = 0; m_brw[i] = 0;
            end else if (load) begin
                m_cnt[i] = lv; m_halt[i] = 0; m_brw[i] = 0;
            end else if (!m_halt[i] && en) begin
                m_brw[i] = 0;
                if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                else if (!mode) begin m_cnt[i] = m_max[i]; m_brw[i] = 1; end
                else m_halt[i] = 1;
            end else begin
                m_brw[i] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("count4",  16'(c4), 16'(m_cnt[0]));
        chk("zero4",   16'(z4), 16'(m_cnt[0] == 0));
        chk("borrow4", 16'(b4), 16'(m_brw[0]));
        chk("done4",   16'(d4), 16'(m_halt[0]));
        chk("count8",  16'(c8), 16'(m_cnt[1]));
        chk("zero8",   16'(z8), 16'(m_cnt[1] == 0));
        chk("borrow8", 16'(b8), 16'(m_brw[1]));
        chk("done8",   16'(d8), 16'(m_halt[1]));
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic m, input logic [7:0] v);
        rst = r; load = l; en = e; mode = m; lv8 = v; lv4 = v[3:0];
    endtask

    initial begin
        int nb;
        int first_b;
        int second_b;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_halt[i] = 0; m_brw[i] = 0; end

        // reset value, then hold with en low
        drive(1, 0, 0, 0, 8'd0);
        cycle(); cycle();
        chk("rst_count4", 16'(c4), 16'd15);
        chk("rst_zero4", 16'(z4), 16'd0);
        chk("rst_done4", 16'(d4), 16'd0);
        drive(0, 0, 0, 0, 8'd0);
        repeat (5) cycle();
        chk("hold_count4", 16'(c4), 16'd15);

        // wrap: 16 edges lands on the borrow cycle, then reset there
        drive(0, 0, 1, 0, 8'd0);
        repeat (15) cycle();
        chk("wrap_at_zero4", 16'(z4), 16'd1);
        cycle();
        chk("wrap_count4", 16'(c4), 16'd15);
        chk("wrap_borrow4", 16'(b4), 16'd1);
        drive(1, 0, 1, 0, 8'd0);
        cycle();
        chk("rst_in_borrow4", 16'(b4), 16'd0);
        chk("rst_in_borrow_cnt4", 16'(c4), 16'd15);
        drive(0, 0, 1, 0, 8'd0);
        cycle();
        chk("after_rst_cnt4", 16'(c4), 16'd14);

        // one-shot from 3
        drive(0, 1, 0, 1, 8'd3);
        cycle();
        drive(0, 0, 1, 1, 8'd0);
        repeat (3) cycle();
        chk("os_zero4", 16'(z4), 16'd1);
        chk("os_not_done4", 16'(d4), 16'd0);
        cycle();
        chk("os_done4", 16'(d4), 16'd1);
        drive(0, 0, 1, 0, 8'd0);
        repeat (10) cycle();
        chk("os_held_cnt4", 16'(c4), 16'd0);
        chk("os_held_done4", 16'(d4), 16'd1);
        drive(0, 1, 1, 1, 8'd5);
        cycle();
        chk("os_reload_cnt4", 16'(c4), 16'd5);
        chk("os_reload_done4", 16'(d4), 16'd0);

        // load 0 one-shot, then reset while halted
        drive(0, 1, 0, 1, 8'd0);
        cycle();
        drive(0, 0, 1, 1, 8'd0);
        cycle();
        chk("load0_done8", 16'(d8), 16'd1);
        drive(1, 0, 1, 1, 8'd0);
        cycle();
        chk("rst_halt_done4", 16'(d4), 16'd0);
        drive(0, 0, 1, 1, 8'd0);
        cycle();
        chk("rst_halt_run4", 16'(c4), 16'd14);

        // priority
        drive(0, 1, 1, 0, 8'd9);
        cycle();
        chk("load_over_en4", 16'(c4), 16'd9);
        drive(1, 1, 1, 0, 8'd9);
        cycle();
        chk("rst_over_load4", 16'(c4), 16'd15);
        chk("rst_over_load8", 16'(c8), 16'd255);

        // WIDTH=8 period sweep
        drive(0, 0, 1, 0, 8'd0);
        nb = 0; first_b = -1; second_b = -1;
        for (int k = 1; k <= 512; k++) begin
            cycle();
            if (b8 === 1'b1) begin
                nb++;
                if (first_b < 0) first_b = k; else second_b = k;
            end
        end
        chk("borrows8", 16'(nb), 16'd2);
        chk("period8", 16'(second_b - first_b), 16'd256);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                  8'($urandom_range(0, 255)));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
